// File: rtl/sd_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sd_init_sequencer
// Purpose  : SD-card power-up and identification sequencer driving the SDIO
//            command engine (CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3, CMD7).
// Revision : 1.0
// ============================================================================
module sd_init_sequencer #(
   parameter logic [15:0] POWERUP_WAIT   = 16'd50000,
   parameter logic [15:0] ACMD41_RETRIES = 16'd1000,
   parameter logic [15:0] RETRY_GAP      = 16'd5000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [5:0]  cmd_index,
   output logic [31:0] cmd_arg,
   output logic [1:0]  cmd_resp_type,
   input  logic        resp_valid,
   input  logic        resp_timeout,
   input  logic        resp_crc_err,
   input  logic [31:0] resp_arg,
   output logic        busy,
   output logic        init_done,
   output logic        init_error,
   output logic [2:0]  error_code,
   output logic [15:0] rca,
   output logic        ccs,
   output logic        fast_clk
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_POWERUP, ST_ISSUE, ST_WAIT_RESP, ST_GAP, ST_DONE, ST_ERROR
   } state_t;

   typedef enum logic [2:0] {
      S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD2, S_CMD3, S_CMD7
   } step_t;

   state_t      state, state_nx;
   step_t       step, step_nx;
   logic [15:0] cnt, cnt_nx, retry, retry_nx;
   logic        v2, v2_nx;
   logic        cmd_valid_nx, busy_nx, init_done_nx, init_error_nx, ccs_nx, fast_clk_nx;
   logic [5:0]  cmd_index_nx;
   logic [31:0] cmd_arg_nx;
   logic [1:0]  cmd_resp_type_nx;
   logic [2:0]  error_code_nx, fail_code;
   logic [15:0] rca_nx;
   logic [5:0]  step_index;
   logic [31:0] step_arg;
   logic [1:0]  step_type;

   always_comb begin
      step_index = 6'd0;
      step_arg   = 32'h0;
      step_type  = 2'd1;
      case (step)
         S_CMD0:   step_type = 2'd0;
         S_CMD8:   begin step_index = 6'd8;  step_arg = 32'h0000_01AA; end
         S_CMD55:  step_index = 6'd55;
         S_ACMD41: begin step_index = 6'd41; step_arg = v2 ? 32'h40FF_8000 : 32'h00FF_8000; end
         S_CMD2:   begin step_index = 6'd2;  step_type = 2'd2; end
         S_CMD3:   step_index = 6'd3;
         S_CMD7:   begin step_index = 6'd7;  step_arg = {rca, 16'h0}; end
         default:  step_type = 2'd0;
      endcase
   end

   always_comb begin
      state_nx         = state;
      step_nx          = step;
      cnt_nx           = cnt;
      retry_nx         = retry;
      v2_nx            = v2;
      cmd_valid_nx     = cmd_valid;
      cmd_index_nx     = cmd_index;
      cmd_arg_nx       = cmd_arg;
      cmd_resp_type_nx = cmd_resp_type;
      init_done_nx     = init_done;
      init_error_nx    = init_error;
      error_code_nx    = error_code;
      rca_nx           = rca;
      ccs_nx           = ccs;
      fast_clk_nx      = fast_clk;
      fail_code        = 3'd0;

      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
               init_done_nx  = 1'b0;
               init_error_nx = 1'b0;
               error_code_nx = 3'd0;
               rca_nx        = 16'h0;
               ccs_nx        = 1'b0;
               fast_clk_nx   = 1'b0;
               retry_nx      = 16'h0;
               v2_nx         = 1'b0;
               cnt_nx        = 16'h0;
               state_nx      = ST_POWERUP;
            end
         end
         ST_POWERUP: begin
            if (cnt == POWERUP_WAIT) begin
               state_nx = ST_ISSUE;
               step_nx  = S_CMD0;
            end else begin
               cnt_nx = cnt + 16'd1;
            end
         end
         ST_ISSUE: begin
            // Fields depend only on step/rca/v2, which are frozen here, so they stay stable.
            if (cmd_valid && cmd_ready) begin
               cmd_valid_nx = 1'b0;
               state_nx     = ST_WAIT_RESP;
            end else begin
               cmd_valid_nx     = 1'b1;
               cmd_index_nx     = step_index;
               cmd_arg_nx       = step_arg;
               cmd_resp_type_nx = step_type;
            end
         end
         ST_WAIT_RESP: begin
            if (resp_timeout) begin
               if (step == S_CMD8) begin
                  v2_nx    = 1'b0;
                  step_nx  = S_CMD55;
                  state_nx = ST_ISSUE;
               end else begin
                  fail_code = 3'd3;
               end
            end else if (resp_valid) begin
               // R3 (ACMD41) carries no valid CRC, so its CRC flag is meaningless.
               if (resp_crc_err && step != S_ACMD41) begin
                  fail_code = 3'd4;
               end else begin
                  state_nx = ST_ISSUE;
                  case (step)
                     S_CMD0: step_nx = S_CMD8;
                     S_CMD8: begin
                        if (resp_arg[11:0] != 12'h1AA) begin
                           fail_code = 3'd1;
                        end else begin
                           v2_nx   = 1'b1;
                           step_nx = S_CMD55;
                        end
                     end
                     S_CMD55: begin
                        if (retry != 16'hFFFF) retry_nx = retry + 16'd1;
                        step_nx = S_ACMD41;
                     end
                     S_ACMD41: begin
                        if (resp_arg[31]) begin
                           ccs_nx  = resp_arg[30] & v2;
                           step_nx = S_CMD2;
                        end else if (retry == ACMD41_RETRIES || ACMD41_RETRIES == 16'd0) begin
                           fail_code = 3'd2;
                        end else begin
                           cnt_nx   = 16'h0;
                           state_nx = ST_GAP;
                        end
                     end
                     S_CMD2: step_nx = S_CMD3;
                     S_CMD3: begin
                        rca_nx  = resp_arg[31:16];
                        step_nx = S_CMD7;
                     end
                     S_CMD7: begin
                        fast_clk_nx  = 1'b1;
                        init_done_nx = 1'b1;
                        state_nx     = ST_DONE;
                     end
                     default: fail_code = 3'd3;
                  endcase
               end
            end
         end
         ST_GAP: begin
            if (cnt == RETRY_GAP) begin
               step_nx  = S_CMD55;
               state_nx = ST_ISSUE;
            end else begin
               cnt_nx = cnt + 16'd1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase

      if (fail_code != 3'd0) begin
         init_error_nx = 1'b1;
         error_code_nx = fail_code;
         state_nx      = ST_ERROR;
      end

      busy_nx = (state_nx == ST_POWERUP) || (state_nx == ST_ISSUE) ||
                (state_nx == ST_WAIT_RESP) || (state_nx == ST_GAP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         step          <= S_CMD0;
         cnt           <= 16'h0;
         retry         <= 16'h0;
         v2            <= 1'b0;
         cmd_valid     <= 1'b0;
         cmd_index     <= 6'd0;
         cmd_arg       <= 32'h0;
         cmd_resp_type <= 2'd0;
         busy          <= 1'b0;
         init_done     <= 1'b0;
         init_error    <= 1'b0;
         error_code    <= 3'd0;
         rca           <= 16'h0;
         ccs           <= 1'b0;
         fast_clk      <= 1'b0;
      end else begin
         state         <= state_nx;
         step          <= step_nx;
         cnt           <= cnt_nx;
         retry         <= retry_nx;
         v2            <= v2_nx;
         cmd_valid     <= cmd_valid_nx;
         cmd_index     <= cmd_index_nx;
         cmd_arg       <= cmd_arg_nx;
         cmd_resp_type <= cmd_resp_type_nx;
         busy          <= busy_nx;
         init_done     <= init_done_nx;
         init_error    <= init_error_nx;
         error_code    <= error_code_nx;
         rca           <= rca_nx;
         ccs           <= ccs_nx;
         fast_clk      <= fast_clk_nx;
      end
   end

endmodule
`default_nettype wire

// File: doc/sd_init_sequencer.md
# sd_init_sequencer

Sequences the SD-card power-up and identification flow (CMD0, CMD8, CMD55/ACMD41 loop, CMD2, CMD3, CMD7) on top of the SDIO command engine, which serialises 48-bit command frames and captures responses. The block owns the command engine's request port during initialisation. It reports the card's RCA and capacity class, and switches the SDIO clock from the identification rate to the transfer rate once the card is selected.

## Interface
- POWERUP_WAIT, 16'd50000: clk cycles of idle before CMD0 (≥74 SD clocks at 400 kHz).
- ACMD41_RETRIES, 16'd1000: maximum CMD55+ACMD41 pairs before giving up.
- RETRY_GAP, 16'd5000: idle clk cycles between ACMD41 attempts.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins or restarts initialisation.
- cmd_valid  out  1  command request to engine.
- cmd_ready  in  1  engine accepts request when cmd_valid && cmd_ready.
- cmd_index  out  6  command index.
- cmd_arg  out  32  command argument.
- cmd_resp_type  out  2  0 = none, 1 = 48-bit, 2 = 136-bit.
- resp_valid  in  1  one-cycle pulse: response received (or frame sent, for type 0).
- resp_timeout  in  1  one-cycle pulse: no response start bit within engine limit.
- resp_crc_err  in  1  qualifies resp_valid: CRC7 mismatch.
- resp_arg  in  32  bits [39:8] of the 48-bit response (don't-care for type 2).
- busy  out  1  sequence in progress.
- init_done  out  1  card is in transfer state; held until start or rst.
- init_error  out  1  sequence aborted; held until start or rst.
- error_code  out  3  1 = CMD8 echo mismatch, 2 = ACMD41 retries exhausted, 3 = timeout, 4 = CRC error.
- rca  out  16  relative card address from CMD3.
- ccs  out  1  card capacity status (1 = SDHC/SDXC).
- fast_clk  out  1  0 = identification clock, 1 = transfer clock.

## Operation
- States: IDLE, POWERUP, ISSUE, WAIT_RESP, GAP, DONE, ERROR. A step register selects the current command: S_CMD0, S_CMD8, S_CMD55, S_ACMD41, S_CMD2, S_CMD3, S_CMD7.
- IDLE/DONE/ERROR + start: clear init_done, init_error, error_code, rca, ccs, fast_clk, retry counter, and the v2 flag. Go to POWERUP. start in any other state is ignored.
- POWERUP: count POWERUP_WAIT cycles, then go to ISSUE with S_CMD0.
- ISSUE: drive cmd_valid=1 with the step's index/arg/type. On handshake go to WAIT_RESP.
- Commands:
  - CMD0: arg 0, type 0.
  - CMD8: arg 0x000001AA, type 1.
  - CMD55: arg 0, type 1.
  - ACMD41: index 41, arg 0x40FF8000 when v2, else 0x00FF8000; type 1.
  - CMD2: arg 0, type 2.
  - CMD3: arg 0, type 1.
  - CMD7: arg {rca,16'h0}, type 1.
- WAIT_RESP exits on resp_valid or resp_timeout. If both pulse together, timeout wins.
- Error priority: resp_timeout → error 3, except on CMD8. resp_valid with resp_crc_err → error 4, except ACMD41, where R3 carries no CRC and the flag is ignored.
- CMD8 handling:
  - Timeout: v2=0, continue to CMD55 (v1 card).
  - resp_arg[11:0] ≠ 0x1AA: error 1.
  - Otherwise v2=1, continue to CMD55.
- CMD55 increments the retry counter.
- ACMD41 handling:
  - resp_arg[31]=1: ccs ← resp_arg[30] & v2, continue to CMD2.
  - Else, if retry counter = ACMD41_RETRIES: error 2.
  - Else go to GAP, wait RETRY_GAP cycles, then CMD55.
- CMD3: rca ← resp_arg[31:16].
- CMD7 success: fast_clk ← 1, init_done ← 1, go to DONE.
- Any error: init_error ← 1, error_code set, go to ERROR. fast_clk stays 0.
- busy = 1 in POWERUP, ISSUE, WAIT_RESP, GAP.

## Timing
- All outputs are registered. Reset values: cmd_valid 0, cmd_index 0, cmd_arg 0, cmd_resp_type 0, busy 0, init_done 0, init_error 0, error_code 0, rca 0, ccs 0, fast_clk 0. State is IDLE.
- start sampled in cycle N → busy=1 from cycle N+1.
- cmd_valid rises the cycle after entering ISSUE.
- cmd_valid and the command fields are held stable until the handshake cycle, and are low in the cycle after it.
- Response sampled in the pulse cycle. The next ISSUE is entered the following cycle, so cmd_valid reasserts 2 cycles after resp_valid.
- Errors and done: init_done/init_error assert the cycle after the deciding pulse; busy falls in the same cycle.
- rst mid-operation: all outputs return to reset values on the next edge, including a pending cmd_valid being dropped. The engine must tolerate an abandoned request.
- Counters are 16-bit, compared with ==, and never wrap. With ACMD41_RETRIES=0, the first not-ready response gives error 2.

## Test plan
- Happy v2 path:
  - Stimulus: CMD8 echo 0x1AA; ACMD41 returns 0x00FF8000 twice, then 0xC0FF8000; CMD3 resp_arg 0x12340000.
  - Required: command order 0,8,55,41,55,41,55,41,2,3,7; CMD7 arg 0x12340000; rca 0x1234, ccs 1, init_done 1, fast_clk 1.
- v1 card:
  - Stimulus: CMD8 resp_timeout; ACMD41 returns 0x80FF8000.
  - Required: ACMD41 arg 0x00FF8000, ccs 0, init_done 1.
- CMD8 echo 0x0AA → init_error 1, error_code 1, no further cmd_valid.
- ACMD41 never ready with ACMD41_RETRIES=3 → exactly 3 CMD55/ACMD41 pairs, each gap ≥ RETRY_GAP cycles, then error_code 2.
- cmd_ready held low 20 cycles in ISSUE → cmd_valid and fields stable throughout.
- rst asserted while waiting for a CMD2 response → all outputs at reset values next cycle. A subsequent start restarts from POWERUP.
- start pulsed during GAP → ignored; sequence completes unchanged.
